// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//
// UART transmitter with a built-in transmit FIFO. Words arrive over a
// valid/ready handshake and go out LSB-first on txd. Frames queued in the
// FIFO are sent back-to-back with no idle gap between them.
//
// Frame: start (0), DATA_BITS data bits, optional parity bit, STOP_BITS
// stop bits (1). Every bit lasts DIV = CLK_FREQ / BAUD clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   - PARITY state and parity generator are built; parity_mode
//               selects 00 none, 01 even, 10 odd, 11 none.
//   undefined - no parity bit is ever sent; parity_mode is ignored.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   tx_data     in   [DATA_BITS]  word to send
//   tx_valid    in   tx_data is valid
//   tx_ready    out  FIFO can accept a word
//   parity_mode in   [2]  parity select, sampled when a word is popped
//   txd         out  registered serial output, idle high
//   busy        out  registered: frame in progress or FIFO non-empty
//   fifo_count  out  [$clog2(FIFO_DEPTH)+1]  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [1:0]                      parity_mode,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // -------------------------------------------------------------------------
  // Transmit FIFO
  // -------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // A full FIFO refuses the word even when a pop happens on the same edge.
  assign tx_ready = !full && !reset;
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are never read because
  // occupancy and pointers are reset, and leaving it unreset keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 last_stop;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic parity_mode_unused;
  assign parity_mode_unused = ^parity_mode;
`endif

  assign bit_end   = (cnt_q == CNT_W'(DIV - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    // The baud counter free-runs through a frame, wrapping at each bit end.
    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!last_stop) begin
            stop_d = 1'b1;
          end else if (!empty) begin
            // Chain straight into the next frame: no idle bit in between.
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the head word and the parity setting at frame start.
    if (pop) begin
      shift_d = head;
      bit_d   = '0;
      cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (^head) ^ (parity_mode == 2'b10);
`endif
    end
  end

  // txd and busy are registered from the current state, so the line trails
  // the FSM by one cycle and each bit is still exactly DIV cycles long.
  always_comb begin
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_bit_q;
`endif
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) || (count_q != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its input from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//
// Bench for uart_tx_param at DIV = 10. Instance A: 8 data bits, 1 stop bit,
// 4-entry FIFO, checked against a queue of expected words by a line monitor.
// Instance B: 7 data bits, 2 stop bits, checked bit-by-bit directly.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] tx_data_a = '0;
  logic       tx_valid_a = 1'b0;
  logic [1:0] parity_mode_a = 2'b00;
  logic       tx_ready_a, txd_a, busy_a;
  logic [2:0] fifo_count_a;

  logic [6:0] tx_data_b = '0;
  logic       tx_valid_b = 1'b0;
  logic [1:0] parity_mode_b = 2'b00;
  logic       tx_ready_b, txd_b, busy_b;
  logic [1:0] fifo_count_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .parity_mode(parity_mode_a), .txd(txd_a),
    .busy(busy_a), .fifo_count(fifo_count_a)
  );

  uart_tx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(2)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .parity_mode(parity_mode_b), .txd(txd_b),
    .busy(busy_b), .fifo_count(fifo_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_a(input logic [7:0] d, input logic [1:0] mode, output int acc_cyc);
    int t;
    tx_data_a = d;
    parity_mode_a = mode;
    tx_valid_a = 1'b1;
    t = 0;
    while (tx_ready_a !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    check("push_ready", tx_ready_a, 1);
    if (tx_ready_a === 1'b1) begin
      @(posedge clk);
      exp_q.push_back('{data: d, mode: mode});
      @(negedge clk);
    end
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int t;
    repeat (2) @(negedge clk);
    t = 0;
    while (busy_a !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_in_budget", busy_a, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Single frame from idle: latency, line timing and busy length.
  task automatic single_frame(input logic [7:0] d, input logic [1:0] mode, input int exp_busy);
    int n, acc;
    push_a(d, mode, acc);
    check("busy_at_push", busy_a, 0);
    n = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy_a !== 1'b1) break;
      n++;
      if (n == 1) begin
        check("txd_high_at_pop", txd_a, 1);
        check("count_after_pop", fifo_count_a, 0);
      end
      if (n == 2) check("txd_fall_latency", txd_a, 0);
    end
    check("busy_cycles", n, exp_busy);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Line monitor for instance A: every bit must hold for all DIV samples
  // and match the frame built from the next expected word.
  initial begin : mon_a
    exp_t        e;
    logic [11:0] bits;
    int          nb;
    logic        obs, stable, abort, par;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && txd_a === 1'b0) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", exp_q.size(), 1);
          for (int i = 0; i < 2000 && txd_a !== 1'b1; i++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
          par = (e.mode == 2'b01) || (e.mode == 2'b10);
`else
          par = 1'b0;
`endif
          bits = '0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
          nb = 9;
          if (par) begin
            bits[nb] = (^e.data) ^ (e.mode == 2'b10);
            nb++;
          end
          bits[nb] = 1'b1;
          nb++;
          abort = 1'b0;
          for (int b = 0; b < nb && !abort; b++) begin
            stable = 1'b1;
            obs = 1'b0;
            for (int s = 0; s < DIV && !abort; s++) begin
              if (b != 0 || s != 0) @(negedge clk);
              if (reset !== 1'b0) abort = 1'b1;
              else if (s == 0) obs = txd_a;
              else if (txd_a !== obs) stable = 1'b0;
            end
            if (!abort) check($sformatf("frame_%02h_bit%0d", e.data, b), {stable, obs}, {1'b1, bits[b]});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          acc, t, s;
    logic [9:0]  got_b, exp_b;
    logic [6:0]  d_b;

    // Reset held for 3 cycles.
    @(negedge clk);
    check("rst_txd_a", txd_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_count_a", fifo_count_a, 0);
    check("rst_ready_a", tx_ready_a, 0);
    check("rst_txd_b", txd_b, 1);
    check("rst_ready_b", tx_ready_b, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_rst_a", tx_ready_a, 1);
    check("ready_after_rst_b", tx_ready_b, 1);
    @(negedge clk);

    // 8N1 single frame.
    single_frame(8'hA5, 2'b00, 101);

`ifdef UART_TX_PARITY_EN
    single_frame(8'h07, 2'b01, 111);
    single_frame(8'h07, 2'b10, 111);
    // parity_mode change mid-frame must not touch the frame in flight.
    push_a(8'h07, 2'b01, acc);
    repeat (30) @(negedge clk);
    parity_mode_a = 2'b10;
    wait_idle_a(300);
    parity_mode_a = 2'b00;
`else
    // Parity logic absent: parity_mode is ignored.
    single_frame(8'h07, 2'b01, 101);
    parity_mode_a = 2'b00;
`endif

    // FIFO full and back-to-back frames.
    start_q.delete();
    for (int i = 0; i < 5; i++) push_a(8'h11 + 8'(i), 2'b00, acc);
    check("ready_low_when_full", tx_ready_a, 0);
    check("count_full", fifo_count_a, 4);
    push_a(8'h16, 2'b00, acc);
    if (start_q.size() > 0) check("ready_rise_at_pop", acc, start_q[0] + 99);
    else check("first_frame_started", start_q.size(), 1);
    check("count_after_6th", fifo_count_a, 4);
    wait_idle_a(1000);
    check("frames_seen", start_q.size(), 6);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("frame_gap%0d", i), start_q[i] - start_q[i-1], 100);
    if (start_q.size() == 6) check("burst_length", start_q[5] + 100 - start_q[0], 600);

    // Reset in the middle of data bit 3 with two words queued.
    push_a(8'h3C, 2'b00, acc);
    push_a(8'h5A, 2'b00, acc);
    push_a(8'h66, 2'b00, acc);
    t = 0;
    while (txd_a !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst_frame_start", txd_a, 0);
    repeat (44) @(negedge clk);
    check("pre_rst_count", fifo_count_a, 2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", txd_a, 1);
    check("mid_rst_count", fifo_count_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_ready", tx_ready_a, 0);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    single_frame(8'h81, 2'b00, 101);

    // Instance B: 7 data bits, 2 stop bits.
    d_b = 7'h55;
    exp_b = '0;
    for (int i = 0; i < 7; i++) exp_b[1+i] = d_b[i];
    exp_b[8] = 1'b1;
    exp_b[9] = 1'b1;
    check("b_ready", tx_ready_b, 1);
    tx_data_b = d_b;
    tx_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid_b = 1'b0;
    t = 0;
    while (txd_b !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b_fall_latency", t, 2);
    got_b = '0;
    for (int b = 0; b < 10; b++) begin
      s = (b == 0) ? DIV / 2 : DIV;
      repeat (s) @(negedge clk);
      got_b[b] = txd_b;
    end
    check("b_frame_bits", got_b, exp_b);
    repeat (4) @(negedge clk);
    check("b_busy_last_cycle", busy_b, 1);
    @(negedge clk);
    check("b_busy_end", busy_b, 0);
    check("b_txd_idle", txd_b, 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a built-in transmit FIFO, for the board-level serial link. Configurable data width, stop bits, baud divisor and FIFO depth; optional runtime parity. Upstream logic pushes words over a valid/ready handshake. The block serialises them LSB-first on `txd` with no idle gap between queued frames.

## Interface
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate. `DIV = CLK_FREQ / BAUD` uses integer division (10416 at defaults). `DIV` must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, legal values 5..8.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a word.
- `parity_mode`  in  2  parity select: 00 none, 01 even, 10 odd, 11 none.
- `txd`  out  1  serial output; idle level is high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Push.** A push occurs on a clock edge where `tx_valid && tx_ready`.
  - `tx_ready = !full && !reset`.
  - A full FIFO rejects a push even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-empty FIFO leaves `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop the head word, latch it and `parity_mode` into the shift register, go to START.
  - START: drive `txd` low for one bit time, then go to DATA.
  - DATA: send `DATA_BITS` bits LSB-first, one bit time each. Then go to PARITY if parity is active, otherwise to STOP.
  - PARITY: send one bit time. Even parity makes the total number of 1s (data plus parity) even; odd parity makes it odd.
  - STOP: drive `txd` high for `STOP_BITS` bit times.
    - At the end of STOP with FIFO non-empty: pop the next word and go directly to START, so the start bit follows on the next cycle.
    - At the end of STOP with FIFO empty: go to IDLE.
- **Baud counter.**
  - Counts 0..DIV-1 and is cleared at frame start, so every bit, the start bit included, lasts exactly DIV cycles.
  - Width is $clog2(DIV).
  - Does not run in IDLE.
- **Runtime inputs.** `parity_mode` is sampled only at pop; changing it mid-frame has no effect on the current frame.
- **Status outputs.**
  - `busy = (state != IDLE) || (fifo_count != 0)`.
  - `txd` is registered.
- **Reset.**
  - At the first edge with `reset` high: `txd` = 1, `busy` = 0, `fifo_count` = 0, state = IDLE, baud counter = 0, FIFO pointers = 0.
  - `tx_ready` is 0 while `reset` is high and 1 after it is released.
  - Reset mid-frame aborts the frame and flushes the FIFO; `txd` returns high at that edge.

## Timing
- **Latency.** With the block idle and the FIFO empty, for a push accepted at edge E0:
  - The pop occurs at E0+1.
  - `txd` falls at E0+2.
  - `busy` rises at E0+1.
- **Frame length.** `(1 + DATA_BITS + P + STOP_BITS) * DIV` cycles, where P = 1 if parity is active, else 0.
- **Back-to-back frames.** The next start bit begins at the edge where the final stop bit ends.
- **`tx_ready`.** Falls at the edge where the FIFO becomes full and rises at the edge of the next pop.
- **End of transmission.** `busy` falls at the edge that ends the last stop bit with the FIFO empty.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The PARITY state and parity generator are built.
  - `parity_mode` behaves as described in Operation.
- **`UART_TX_PARITY_EN` undefined:**
  - The PARITY state is not built; the parity bit is never sent.
  - `parity_mode` stays on the port but is ignored.
  - Frame length is `(1 + DATA_BITS + STOP_BITS) * DIV` cycles.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000 (DIV=10) unless stated otherwise.
- **Reset:** hold `reset` 3 cycles -> `txd`=1, `busy`=0, `fifo_count`=0, `tx_ready`=0 during reset and 1 after.
- **Single frame, 8N1:** push 0xA5 -> `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; `txd` falls 2 cycles after the push; `busy` high for 101 cycles.
- **Parity (macro defined):** push 0x07 with mode 01 -> parity bit 1; with mode 10 -> parity bit 0; frame is 110 cycles. Toggle `parity_mode` mid-frame -> no change to the current frame.
- **FIFO full, FIFO_DEPTH=4:** push 6 words 0x11..0x16 on consecutive cycles while idle -> first word pops immediately; `tx_ready`=0 after the 5th push; 6th accepted at the first STOP→START pop; 6 contiguous frames, 600 cycles total, no idle high gap between frames.
- **Reset mid-frame:** assert reset during data bit 3 of 0x3C with 2 words queued -> `txd`=1 and `fifo_count`=0 at the next edge. A subsequent push of 0x81 is transmitted intact.
- **DATA_BITS=7, STOP_BITS=2, no parity:** push 0x55 -> frame 0,1,0,1,0,1,0,1,1,1, total 100 cycles.
